// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the ID/EX/MEM stage logic and the hazard sequencer.
// The pipeline side drives the master modport. The sequencer uses the slave modport.
interface pipeline_hazard_ctrl_if;
  logic [4:0] ID_RS;
  logic [4:0] ID_RT;
  logic       ID_UsesRT;
  logic       ID_MulDiv;
  logic       ID_BranchTaken;
  logic       EX_MEM_RDEN;
  logic [4:0] EX_RT;
  logic       MEM_Req;
  logic       MEM_Ready;
  logic       PC_Stall;
  logic       IF_ID_Stall;
  logic       IF_ID_Flush;
  logic       ID_EX_Stall;
  logic       ID_EX_Flush;
  logic       EX_MEM_Stall;
  logic       EX_MEM_Flush;
  logic       MEM_WB_Flush;
  logic       MulDiv_Busy;
  logic       Mem_Error;

  modport master (
    output ID_RS, ID_RT, ID_UsesRT, ID_MulDiv, ID_BranchTaken,
    output EX_MEM_RDEN, EX_RT, MEM_Req, MEM_Ready,
    input  PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
    input  EX_MEM_Stall, EX_MEM_Flush, MEM_WB_Flush, MulDiv_Busy, Mem_Error
  );

  modport slave (
    input  ID_RS, ID_RT, ID_UsesRT, ID_MulDiv, ID_BranchTaken,
    input  EX_MEM_RDEN, EX_RT, MEM_Req, MEM_Ready,
    output PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
    output EX_MEM_Stall, EX_MEM_Flush, MEM_WB_Flush, MulDiv_Busy, Mem_Error
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// It resolves memory wait, MUL/DIV occupancy, load-use and taken-branch conditions, in that priority order.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int MEM_TIMEOUT   = 255
) (
  input logic                   clock,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    COND_NONE,
    COND_MEMWAIT,
    COND_BUSY,
    COND_LOADUSE,
    COND_BRANCH
  } cond_t;

  localparam logic [3:0]  CNT_LOAD = 4'(MULDIV_CYCLES - 1);
  localparam logic [16:0] TIMEOUT  = 17'(MEM_TIMEOUT);

  logic [3:0]  r_cnt;
  logic [15:0] r_wcnt;
  logic        r_memError;

  logic        w_mw;
  logic        w_lu;
  logic        w_busy;
  logic        w_issue;
  logic [15:0] w_wcntNext;
  logic        w_timeout;
  cond_t       w_cond;

  assign w_mw   = bus.MEM_Req & ~bus.MEM_Ready;
  assign w_busy = (r_cnt != 4'd0);
  assign w_lu   = bus.EX_MEM_RDEN & (bus.EX_RT != 5'd0) &
                  ((bus.EX_RT == bus.ID_RS) | (bus.ID_UsesRT & (bus.EX_RT == bus.ID_RT)));

  // A MUL/DIV only leaves ID on a cycle where nothing holds the front of the pipe.
  assign w_issue = bus.ID_MulDiv & ~w_mw & ~w_busy & ~w_lu;

  assign w_wcntNext = !w_mw             ? 16'd0  :
                      (r_wcnt == 16'hFFFF) ? r_wcnt : r_wcnt + 16'd1;
  assign w_timeout  = w_mw & ({1'b0, w_wcntNext} >= TIMEOUT);

  // The occupancy counter freezes during memory wait, so the MUL/DIV gets its full count of productive cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (!w_mw) begin
      if (w_busy) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (w_issue) begin
        r_cnt <= CNT_LOAD;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wcnt     <= 16'd0;
      r_memError <= 1'b0;
    end else begin
      r_wcnt <= w_wcntNext;
      if (w_timeout) begin
        r_memError <= 1'b1;
      end
    end
  end

  always_comb begin
    w_cond = COND_NONE;
    if (reset) begin
      w_cond = COND_NONE;
    end else if (w_mw) begin
      w_cond = COND_MEMWAIT;
    end else if (w_busy) begin
      w_cond = COND_BUSY;
    end else if (w_lu) begin
      w_cond = COND_LOADUSE;
    end else if (bus.ID_BranchTaken) begin
      w_cond = COND_BRANCH;
    end
  end

  // A branch stalled by any higher condition stays in ID unflushed and re-resolves later.
  always_comb begin
    bus.PC_Stall     = 1'b0;
    bus.IF_ID_Stall  = 1'b0;
    bus.IF_ID_Flush  = 1'b0;
    bus.ID_EX_Stall  = 1'b0;
    bus.ID_EX_Flush  = 1'b0;
    bus.EX_MEM_Stall = 1'b0;
    bus.EX_MEM_Flush = 1'b0;
    bus.MEM_WB_Flush = 1'b0;
    case (w_cond)
      COND_MEMWAIT: begin
        bus.PC_Stall     = 1'b1;
        bus.IF_ID_Stall  = 1'b1;
        bus.ID_EX_Stall  = 1'b1;
        bus.EX_MEM_Stall = 1'b1;
        bus.MEM_WB_Flush = 1'b1;
      end
      COND_BUSY: begin
        bus.PC_Stall     = 1'b1;
        bus.IF_ID_Stall  = 1'b1;
        bus.ID_EX_Stall  = 1'b1;
        bus.EX_MEM_Flush = 1'b1;
      end
      COND_LOADUSE: begin
        bus.PC_Stall     = 1'b1;
        bus.IF_ID_Stall  = 1'b1;
        bus.ID_EX_Flush  = 1'b1;
      end
      COND_BRANCH: begin
        bus.IF_ID_Flush  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.MulDiv_Busy = w_busy;
  assign bus.Mem_Error   = r_memError;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with MULDIV_CYCLES=4 and MEM_TIMEOUT=3.
// Output vector order: PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush, EX_MEM_Stall, EX_MEM_Flush, MEM_WB_Flush, MulDiv_Busy, Mem_Error.
module tb_pipeline_hazard_ctrl;

  localparam logic [9:0] P_NONE = 10'b0000000000;
  localparam logic [9:0] P_MW   = 10'b1101010100;
  localparam logic [9:0] P_BUSY = 10'b1101001010;
  localparam logic [9:0] P_LU   = 10'b1100100000;
  localparam logic [9:0] P_BR   = 10'b0010000000;
  localparam logic [9:0] B_BUSY = 10'b0000000010;
  localparam logic [9:0] B_ERR  = 10'b0000000001;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  pipeline_hazard_ctrl_if bus();

  pipeline_hazard_ctrl #(
    .MULDIV_CYCLES(4),
    .MEM_TIMEOUT  (3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [9:0] outVec;
  assign outVec = {bus.PC_Stall, bus.IF_ID_Stall, bus.IF_ID_Flush, bus.ID_EX_Stall,
                   bus.ID_EX_Flush, bus.EX_MEM_Stall, bus.EX_MEM_Flush, bus.MEM_WB_Flush,
                   bus.MulDiv_Busy, bus.Mem_Error};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                               input logic mulDiv, input logic branch, input logic rdEn,
                               input logic [4:0] exRt, input logic memReq, input logic memReady);
    bus.ID_RS          = rs;
    bus.ID_RT          = rt;
    bus.ID_UsesRT      = usesRt;
    bus.ID_MulDiv      = mulDiv;
    bus.ID_BranchTaken = branch;
    bus.EX_MEM_RDEN    = rdEn;
    bus.EX_RT          = exRt;
    bus.MEM_Req        = memReq;
    bus.MEM_Ready      = memReady;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %b required %b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("reset_active", outVec, P_NONE);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset_released", outVec, P_NONE);

    // Load-use on RS, then the zero-register exemption
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    checkOutput("lu_rs", outVec, P_LU);
    tick();
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
    checkOutput("lu_one_bubble", outVec, P_NONE);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    checkOutput("lu_r0", outVec, P_NONE);
    tick();

    // RT hazard gated by ID_UsesRT
    applyStimulus(5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    checkOutput("lu_rt_used", outVec, P_LU);
    applyStimulus(5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    checkOutput("lu_rt_unused", outVec, P_NONE);
    tick();

    // Branch against load-use, then a lone branch
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    checkOutput("br_with_lu", outVec, P_LU);
    tick();
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
    checkOutput("br_after_lu", outVec, P_BR);
    tick();
    applyStimulus(5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("br_alone", outVec, P_BR);
    tick();

    // Back-to-back MUL: three busy cycles each, second MUL held in ID
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("mul1_issue", outVec, P_NONE);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("mul1_busy%0d", i), outVec, P_BUSY);
      tick();
    end
    checkOutput("mul2_issue", outVec, P_NONE);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("mul2_busy%0d", i), outVec, P_BUSY);
      tick();
    end
    checkOutput("mul2_done", outVec, P_NONE);

    // Memory wait in the middle of a MUL freezes the counter
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("mul3_issue", outVec, P_NONE);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("mul3_busy0", outVec, P_BUSY);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("mul3_mw%0d", i), outVec, P_MW | B_BUSY);
      tick();
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    checkOutput("mul3_busy1", outVec, P_BUSY);
    tick();
    checkOutput("mul3_busy2", outVec, P_BUSY);
    tick();
    checkOutput("mul3_done", outVec, P_NONE);

    // Memory wait on the would-be issue edge blocks the MUL
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    checkOutput("mw_blocks_issue", outVec, P_MW);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("mw_no_load", outVec, P_NONE);
    tick();

    // Watchdog trips after three consecutive wait cycles
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    checkOutput("wd_wait0", outVec, P_MW);
    tick();
    checkOutput("wd_wait1", outVec, P_MW);
    tick();
    checkOutput("wd_wait2", outVec, P_MW);
    tick();
    checkOutput("wd_trip", outVec, P_MW | B_ERR);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    checkOutput("wd_ready", outVec, B_ERR);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("wd_sticky", outVec, B_ERR);

    // Asynchronous reset mid-MUL, with load-use inputs still driven
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    checkOutput("rst_pre_busy", outVec, P_BUSY | B_ERR);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async", outVec, P_NONE);
    tick();
    reset = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("rst_release", outVec, P_NONE);
    tick();
    checkOutput("rst_idle", outVec, P_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
